// File: rtl/modbus_pkg.sv
// Shared Modbus definitions for the slave transmit and receive paths.
//   - function codes and exception codes
//   - CRC-16/Modbus constants and a single-bit CRC step helper
//   - transmit FSM state encoding and response frame kinds
package modbus_pkg;

  // Function codes handled by the slave
  localparam logic [7:0] FC_READ_HOLDING  = 8'h03;
  localparam logic [7:0] FC_READ_INPUT    = 8'h04;
  localparam logic [7:0] FC_WRITE_SINGLE  = 8'h06;

  // Exception codes
  localparam logic [7:0] EX_ILLEGAL_FUNCTION   = 8'h01;
  localparam logic [7:0] EX_ILLEGAL_DATA_ADDR  = 8'h02;
  localparam logic [7:0] EX_ILLEGAL_DATA_VALUE = 8'h03;
  localparam logic [7:0] EX_SLAVE_FAILURE      = 8'h04;

  // CRC-16/Modbus (reflected polynomial, processed LSB first)
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // Transmit FSM state encoding
  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_LOAD        = 3'd1;
  localparam logic [2:0] ST_FETCH       = 3'd2;
  localparam logic [2:0] ST_SEND        = 3'd3;
  localparam logic [2:0] ST_CRC         = 3'd4;
  localparam logic [2:0] ST_SEND_CRC_LO = 3'd5;
  localparam logic [2:0] ST_SEND_CRC_HI = 3'd6;
  localparam logic [2:0] ST_FIN         = 3'd7;

  // Shape of the response body (everything between address and CRC)
  typedef enum logic [1:0] {
    FRAME_EXCEPTION = 2'd0,
    FRAME_READ      = 2'd1,
    FRAME_WRITE     = 2'd2
  } frame_kind_e;

  // One bit of the CRC: fold the incoming data bit into the LSB and shift.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        bit_in);
    logic [15:0] shifted;
    shifted = {1'b0, crc[15:1]};
    return (crc[0] ^ bit_in) ? (shifted ^ CRC_POLY) : shifted;
  endfunction

endpackage

// File: rtl/crc16_modbus_serial.sv
// Bit-serial CRC-16/Modbus engine, shared with the receive path.
//   clk_in  : system clock (rising edge)
//   rst_in  : asynchronous active-high reset (CRC register -> CRC_INIT)
//   load    : reinitialise the CRC register to CRC_INIT for a new frame
//   start   : accept byte_in and fold it in over the next 8 cycles
//   byte_in : byte to accumulate (sampled on the start cycle)
//   busy    : high while the 8-cycle update is in progress
//   crc_out : current CRC value (final once busy is low)
module crc16_modbus_serial
  import modbus_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load,
  input  logic        start,
  input  logic [7:0]  byte_in,
  output logic        busy,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q,   crc_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  cnt_q,   cnt_d;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    crc_d   = crc_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      crc_d = CRC_INIT;
      cnt_d = 4'd0;
    end else if (start && cnt_q == 4'd0) begin
      shift_d = byte_in;
      cnt_d   = 4'd8;
    end else if (cnt_q != 4'd0) begin
      crc_d   = crc16_step(crc_q, shift_q[0]);
      shift_d = {1'b0, shift_q[7:1]};
      cnt_d   = cnt_q - 4'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      crc_q   <= CRC_INIT;
      shift_q <= 8'h00;
      cnt_q   <= 4'd0;
    end else begin
      crc_q   <= crc_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (cnt_q != 4'd0);
  assign crc_out = crc_q;

endmodule

// File: rtl/modbus_tx_response.sv
// Modbus RTU slave response builder: turns a decoded request (or an
// exception code) into a byte stream with a trailing CRC-16.
//   clk_in, rst_in        : clock and asynchronous active-high reset
//   start                 : one-cycle request pulse, accepted only while idle
//   exception             : exception code, 0 for a normal response
//   func_code, addr, data : request fields (data = quantity or write value)
//   rd_en, rd_addr        : register read strobe/address
//   rd_data               : register data, valid the cycle after rd_en
//   tx_data/valid/ready   : byte handshake towards the UART transmitter
//   busy                  : a response is in progress
//   done                  : one-cycle pulse once the last byte is accepted
module modbus_tx_response
  import modbus_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter int         MAX_QTY    = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [7:0]  exception,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  logic [2:0]  state_q,    state_d;
  frame_kind_e kind_q,     kind_d;
  logic [7:0]  ex_q,       ex_d;
  logic [7:0]  func_q,     func_d;
  logic [15:0] addr_q,     addr_d;
  logic [15:0] data_q,     data_d;
  logic [8:0]  idx_q,      idx_d;    // index of the next body byte
  logic [8:0]  last_q,     last_d;   // body length (bytes before the CRC)
  logic [15:0] word_q,     word_d;   // register word being sent
  logic [7:0]  tx_data_q,  tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        rd_en_q,    rd_en_d;
  logic [15:0] rd_addr_q,  rd_addr_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;

  logic        crc_load;
  logic        crc_start;
  logic        crc_busy;
  logic [15:0] crc_out;

  logic [7:0]  qty;
  logic        qty_ok;
  logic        is_read_fc;
  logic        need_fetch;
  logic [8:0]  word_idx;
  logic [7:0]  next_byte;

  assign qty        = data[7:0];
  assign qty_ok     = (qty != 8'd0) && (int'(qty) <= MAX_QTY);
  assign is_read_fc = (func_code == FC_READ_HOLDING) || (func_code == FC_READ_INPUT);

  // Read bodies carry register words from body offset 3 on; each word's
  // high byte sits at an odd index and must be fetched before it is sent.
  assign need_fetch = (kind_q == FRAME_READ) && (idx_q >= 9'd3) && idx_q[0];
  assign word_idx   = (idx_q - 9'd3) >> 1;

  // Body byte at idx_q for every case that does not need a fresh fetch.
  always_comb begin
    next_byte = word_q[7:0];
    if (idx_q == 9'd0) begin
      next_byte = SLAVE_ADDR;
    end else if (idx_q == 9'd1) begin
      next_byte = (kind_q == FRAME_EXCEPTION) ? (func_q | 8'h80) : func_q;
    end else if (idx_q == 9'd2) begin
      case (kind_q)
        FRAME_EXCEPTION: next_byte = ex_q;
        FRAME_WRITE:     next_byte = addr_q[15:8];
        default:         next_byte = {data_q[6:0], 1'b0};  // byte count = 2*qty
      endcase
    end else if (kind_q == FRAME_WRITE) begin
      case (idx_q)
        9'd3:    next_byte = addr_q[7:0];
        9'd4:    next_byte = data_q[15:8];
        default: next_byte = data_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    ex_d       = ex_q;
    func_d     = func_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    last_d     = last_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    crc_load   = 1'b0;
    crc_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          func_d  = func_code;
          addr_d  = addr;
          data_d  = data;
          idx_d   = 9'd0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
          // Anything that cannot be answered normally becomes a slave
          // device failure exception.
          if (exception != 8'h00) begin
            kind_d = FRAME_EXCEPTION;
            ex_d   = exception;
            last_d = 9'd3;
          end else if (func_code == FC_WRITE_SINGLE) begin
            kind_d = FRAME_WRITE;
            ex_d   = 8'h00;
            last_d = 9'd6;
          end else if (is_read_fc && qty_ok) begin
            kind_d = FRAME_READ;
            ex_d   = 8'h00;
            last_d = 9'd3 + {qty, 1'b0};
          end else begin
            kind_d = FRAME_EXCEPTION;
            ex_d   = EX_SLAVE_FAILURE;
            last_d = 9'd3;
          end
        end
      end

      ST_LOAD: begin
        crc_load   = 1'b1;
        tx_data_d  = SLAVE_ADDR;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end

      ST_FETCH: begin
        // First cycle drives rd_en; the second captures the returned word.
        if (!rd_en_q) begin
          word_d     = rd_data;
          tx_data_d  = rd_data[15:8];
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          crc_start  = 1'b1;
          idx_d      = idx_q + 9'd1;
          state_d    = ST_CRC;
        end
      end

      ST_CRC: begin
        if (!crc_busy) begin
          if (idx_q == last_q) begin
            tx_data_d  = crc_out[7:0];
            tx_valid_d = 1'b1;
            state_d    = ST_SEND_CRC_LO;
          end else if (need_fetch) begin
            rd_en_d   = 1'b1;
            rd_addr_d = addr_q + {7'd0, word_idx};  // 16-bit wrap is intended
            state_d   = ST_FETCH;
          end else begin
            tx_data_d  = next_byte;
            tx_valid_d = 1'b1;
            state_d    = ST_SEND;
          end
        end
      end

      ST_SEND_CRC_LO: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_SEND_CRC_HI;
        end
      end

      ST_SEND_CRC_HI: begin
        // Entered with tx_valid low, which gives the required idle gap.
        if (!tx_valid_q) begin
          tx_data_d  = crc_out[15:8];
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_FIN;
        end
      end

      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      kind_q     <= FRAME_EXCEPTION;
      ex_q       <= 8'h00;
      func_q     <= 8'h00;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      idx_q      <= 9'd0;
      last_q     <= 9'd0;
      word_q     <= 16'h0000;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      ex_q       <= ex_d;
      func_q     <= func_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  crc16_modbus_serial u_crc (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load    (crc_load),
    .start   (crc_start),
    .byte_in (tx_data_q),
    .busy    (crc_busy),
    .crc_out (crc_out)
  );

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_modbus_tx_response.sv
// Bench for modbus_tx_response: directed frames with known CRCs, then
// randomized requests checked against a frame-level reference model.
module tb_modbus_tx_response;

  localparam logic [7:0] SA   = 8'h01;
  localparam int         MAXQ = 5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  exception = 8'h00;
  logic [7:0]  func_code = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [15:0] rd_data = 16'h0000;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  modbus_tx_response #(.SLAVE_ADDR(SA), .MAX_QTY(MAXQ)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (start),
    .exception (exception),
    .func_code (func_code),
    .addr      (addr),
    .data      (data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  // Register file model: content is a fixed scramble of the address.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  always @(posedge clk_in) if (rd_en) rd_data <= mem_val(rd_addr);

  // ---------------- reference model ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] exp_ra[$];

  task automatic build_expected(input logic [7:0] ex, input logic [7:0] f,
                                input logic [15:0] a, input logic [15:0] d);
    logic [7:0]  eff;
    logic [15:0] crc;
    logic [15:0] ra;
    int qty;
    exp_q.delete();
    exp_ra.delete();
    qty = int'(d[7:0]);
    eff = ex;
    if (ex == 8'h00 && f != 8'h06 &&
        !((f == 8'h03 || f == 8'h04) && qty >= 1 && qty <= MAXQ))
      eff = 8'h04;
    if (eff != 8'h00) begin
      exp_q = '{SA, f | 8'h80, eff};
    end else if (f == 8'h06) begin
      exp_q = '{SA, f, a[15:8], a[7:0], d[15:8], d[7:0]};
    end else begin
      exp_q = '{SA, f, 8'(2 * qty)};
      for (int k = 0; k < qty; k++) begin
        ra = a + 16'(k);
        exp_ra.push_back(ra);
        exp_q.push_back(mem_val(ra) >> 8);
        exp_q.push_back(mem_val(ra) & 16'h00FF);
      end
    end
    crc = 16'hFFFF;
    foreach (exp_q[i]) begin
      crc = crc ^ {8'h00, exp_q[i]};
      for (int b = 0; b < 8; b++)
        crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
    end
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
  endtask

  // ---------------- stimulus / capture ----------------
  logic [7:0]  got_q[$];
  logic [15:0] ra_q[$];
  int          gap_q[$];
  bit          timed_out;
  bit          done_single;
  int          unstable;

  task automatic send_start(input logic [7:0] ex, input logic [7:0] f,
                            input logic [15:0] a, input logic [15:0] d);
    @(negedge clk_in);
    exception = ex;
    func_code = f;
    addr      = a;
    data      = d;
    start     = 1'b1;
  endtask

  // Acts as the UART: holds tx_ready low for 'hold' cycles per byte,
  // records bytes, read addresses and idle gaps until done.
  task automatic collect(input int hold, input int repulse_at);
    int cyc = 0;
    int wait_cnt = 0;
    int gap = 0;
    bit holding = 1'b0;
    bit fin = 1'b0;
    logic [7:0] held = 8'h00;
    got_q.delete();
    ra_q.delete();
    gap_q.delete();
    unstable    = 0;
    timed_out   = 1'b0;
    done_single = 1'b0;
    while (!fin && cyc < 4000) begin
      @(negedge clk_in);
      cyc++;
      start = 1'b0;
      if (cyc == repulse_at) begin
        start     = 1'b1;
        exception = 8'h00;
        func_code = 8'h06;
        addr      = 16'h1234;
        data      = 16'hBEEF;
      end
      if (rd_en) ra_q.push_back(rd_addr);
      if (tx_valid) begin
        if (!holding) begin
          holding  = 1'b1;
          held     = tx_data;
          wait_cnt = 0;
          gap_q.push_back(gap);
        end else if (tx_data !== held) begin
          unstable++;
        end
        gap = 0;
        if (wait_cnt >= hold) begin
          tx_ready = 1'b1;
          got_q.push_back(tx_data);
          holding = 1'b0;
        end else begin
          tx_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        tx_ready = (hold == 0);
        gap++;
      end
      if (done) fin = 1'b1;
    end
    if (!fin) timed_out = 1'b1;
    else begin
      @(negedge clk_in);
      done_single = !done && !busy;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({tx_valid, tx_data, rd_en, rd_addr, busy, done} !== 28'h0) begin
      failures++;
      $display("FAIL reset_state got valid=%b data=%h rd_en=%b rd_addr=%h busy=%b done=%b want all 0",
               tx_valid, tx_data, rd_en, rd_addr, busy, done);
    end
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_exception_frame();
    send_start(8'h02, 8'h03, 16'h0000, 16'h0001);
    @(negedge clk_in);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL exc_busy got %b want 1", busy);
    end
    collect(0, 0);
    exp_q = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL exc_len got %0d bytes (timeout=%b) want %0d", got_q.size(), timed_out, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL exc_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (!done_single) begin
      failures++;
      $display("FAIL exc_done_pulse got done=%b busy=%b after pulse want 0 0", done, busy);
    end
  endtask

  task automatic test_write_echo();
    send_start(8'h00, 8'h06, 16'h0001, 16'h0003);
    collect(0, 0);
    exp_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL wr_len got %0d bytes (timeout=%b) want %0d", got_q.size(), timed_out, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wr_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_read_regs(input int hold);
    send_start(8'h00, 8'h04, 16'h0002, 16'h0003);
    collect(hold, 0);
    build_expected(8'h00, 8'h04, 16'h0002, 16'h0003);
    checks++;
    if (ra_q.size() != 3 || ra_q[0] !== 16'h2 || ra_q[1] !== 16'h3 || ra_q[2] !== 16'h4) begin
      failures++;
      $display("FAIL rd_addr_seq got %p want 2 3 4", ra_q);
    end
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rd_len hold=%0d got %0d bytes (timeout=%b) want %0d", hold, got_q.size(), timed_out, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rd_byte%0d hold=%0d got %h want %h", i, hold, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL rd_stable hold=%0d got %0d changes while waiting want 0", hold, unstable);
    end
  endtask

  task automatic test_busy_ignore();
    int stray = 0;
    send_start(8'h00, 8'h10, 16'h0000, 16'h0001);
    collect(1, 5);
    build_expected(8'h00, 8'h10, 16'h0000, 16'h0001);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ign_len got %0d bytes (timeout=%b) want %0d", got_q.size(), timed_out, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ign_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    repeat (10) begin
      @(negedge clk_in);
      if (tx_valid || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL ign_no_second_frame got %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int cyc = 0;
    int stray = 0;
    bit found = 1'b0;
    send_start(8'h00, 8'h03, 16'h0010, 16'h0002);
    tx_ready = 1'b1;
    while (!found && cyc < 500) begin
      @(negedge clk_in);
      start = 1'b0;
      cyc++;
      if (tx_valid) begin
        if (n == 3) found = 1'b1;
        else n++;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rstmid_reach_byte3 got %0d bytes want 3 before timeout", n);
    end
    rst_in   = 1'b1;
    tx_ready = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_data, rd_en, rd_addr, busy, done} !== 28'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got valid=%b data=%h rd_en=%b rd_addr=%h busy=%b done=%b want all 0",
               tx_valid, tx_data, rd_en, rd_addr, busy, done);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      if (tx_valid || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rstmid_no_resume got %0d active cycles want 0", stray);
    end
    send_start(8'h00, 8'h03, 16'h0010, 16'h0002);
    collect(0, 0);
    build_expected(8'h00, 8'h03, 16'h0010, 16'h0002);
    checks++;
    if (timed_out || got_q != exp_q) begin
      failures++;
      $display("FAIL rstmid_frame got %p want %p", got_q, exp_q);
    end
  endtask

  task automatic test_random(input int frames);
    logic [7:0]  fcs[7] = '{8'h03, 8'h04, 8'h06, 8'h10, 8'h01, 8'h03, 8'h04};
    logic [7:0]  ex, f;
    logic [15:0] a, d;
    int hold, short_gaps;
    for (int t = 0; t < frames; t++) begin
      f  = fcs[$urandom_range(0, 6)];
      ex = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 4)) : 8'h00;
      a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      d  = {8'($urandom), 8'($urandom_range(0, 7))};
      hold = $urandom_range(0, 3);
      send_start(ex, f, a, d);
      collect(hold, 0);
      build_expected(ex, f, a, d);
      checks++;
      if (timed_out || got_q != exp_q) begin
        failures++;
        $display("FAIL rnd%0d_frame ex=%h f=%h a=%h d=%h got %p want %p", t, ex, f, a, d, got_q, exp_q);
      end
      checks++;
      if (ra_q != exp_ra) begin
        failures++;
        $display("FAIL rnd%0d_rd_addr got %p want %p", t, ra_q, exp_ra);
      end
      short_gaps = 0;
      for (int i = 1; i < gap_q.size() - 1; i++)
        if (gap_q[i] < 8) short_gaps++;
      checks++;
      if (short_gaps != 0 || !done_single) begin
        failures++;
        $display("FAIL rnd%0d_timing got %0d short CRC gaps done_ok=%b want 0 1", t, short_gaps, done_single);
      end
    end
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog got no finish want finish before 800us");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exception_frame();
    test_write_echo();
    test_read_regs(0);
    test_read_regs(20);
    test_busy_ignore();
    test_reset_mid();
    test_random(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
